// File: rtl/idli_pc_ctl_m_if.sv
// rtl/idli_pc_ctl_m_if.sv - request/ack and PC-block signal bundle for idli_pc_ctl_m
// Interrupt members exist only when IDLI_PCC_IRQ_EN is defined.
interface idli_pc_ctl_m_if;
  logic        i_pcc_fetch_req;
  logic        o_pcc_fetch_ack;
  logic        i_pcc_br_vld;
  logic [15:0] i_pcc_br_tgt;
  logic        o_pcc_br_rdy;
  logic [3:0]  i_pcc_pc_next;
  logic [1:0]  o_pcc_ctr;
  logic        o_pcc_inc;
  logic        o_pcc_redirect;
  logic [3:0]  o_pcc_data;
`ifdef IDLI_PCC_IRQ_EN
  logic        i_pcc_irq;
  logic        o_pcc_irq_ack;
  logic [15:0] o_pcc_epc;

  modport master (
    output i_pcc_fetch_req, i_pcc_br_vld, i_pcc_br_tgt, i_pcc_pc_next, i_pcc_irq,
    input  o_pcc_fetch_ack, o_pcc_br_rdy, o_pcc_ctr, o_pcc_inc, o_pcc_redirect,
           o_pcc_data, o_pcc_irq_ack, o_pcc_epc
  );

  modport slave (
    input  i_pcc_fetch_req, i_pcc_br_vld, i_pcc_br_tgt, i_pcc_pc_next, i_pcc_irq,
    output o_pcc_fetch_ack, o_pcc_br_rdy, o_pcc_ctr, o_pcc_inc, o_pcc_redirect,
           o_pcc_data, o_pcc_irq_ack, o_pcc_epc
  );
`else
  modport master (
    output i_pcc_fetch_req, i_pcc_br_vld, i_pcc_br_tgt, i_pcc_pc_next,
    input  o_pcc_fetch_ack, o_pcc_br_rdy, o_pcc_ctr, o_pcc_inc, o_pcc_redirect,
           o_pcc_data
  );

  modport slave (
    input  i_pcc_fetch_req, i_pcc_br_vld, i_pcc_br_tgt, i_pcc_pc_next,
    output o_pcc_fetch_ack, o_pcc_br_rdy, o_pcc_ctr, o_pcc_inc, o_pcc_redirect,
           o_pcc_data
  );
`endif
endinterface

// File: rtl/idli_pc_ctl_m.sv
// rtl/idli_pc_ctl_m.sv - PC slice sequencer: slice counter plus HOLD/INC/REDIR window arbiter
// Interrupt redirect and EPC capture are compiled in with IDLI_PCC_IRQ_EN.
module idli_pc_ctl_m (
  input  logic            i_pcc_gck,
  input  logic            i_pcc_rst_n,
  idli_pc_ctl_m_if.slave  bus
);
  typedef logic [15:0] data_t;
  typedef logic [1:0]  ctr_t;
  typedef enum logic [1:0] {
    MODE_HOLD  = 2'd0,
    MODE_INC   = 2'd1,
    MODE_REDIR = 2'd2
  } mode_e;

  localparam data_t IRQ_VECTOR = 16'hFFF0;

  ctr_t  ctr_q, ctr_d;
  mode_e mode_q, mode_d;
  data_t tgt_q, tgt_d;
  logic  decide;
  logic  irq_req;
  logic  fetch_ack;
  logic  br_rdy;

  assign decide = (ctr_q == 2'd3);

`ifdef IDLI_PCC_IRQ_EN
  logic  irq_win_q, irq_win_d;
  data_t epc_q, epc_d;

  assign irq_req = bus.i_pcc_irq;
`else
  logic  unused_pc_next;

  assign irq_req        = 1'b0;
  assign unused_pc_next = ^bus.i_pcc_pc_next;
`endif

  always_ff @(posedge i_pcc_gck or negedge i_pcc_rst_n) begin
    if (!i_pcc_rst_n) begin
      ctr_q     <= '0;
      mode_q    <= MODE_HOLD;
      tgt_q     <= '0;
`ifdef IDLI_PCC_IRQ_EN
      irq_win_q <= 1'b0;
      epc_q     <= '0;
`endif
    end else begin
      ctr_q     <= ctr_d;
      mode_q    <= mode_d;
      tgt_q     <= tgt_d;
`ifdef IDLI_PCC_IRQ_EN
      irq_win_q <= irq_win_d;
      epc_q     <= epc_d;
`endif
    end
  end

  // The mode is only re-chosen at ctr = 3 so a window never changes action midway.
  always_comb begin
    ctr_d     = ctr_q + 2'd1;
    mode_d    = mode_q;
    tgt_d     = tgt_q;
    fetch_ack = 1'b0;
    br_rdy    = 1'b0;
    if (decide) begin
      mode_d = MODE_HOLD;
      if (irq_req) begin
        mode_d = MODE_REDIR;
        tgt_d  = IRQ_VECTOR;
      end else if (bus.i_pcc_br_vld) begin
        mode_d = MODE_REDIR;
        tgt_d  = bus.i_pcc_br_tgt;
        br_rdy = 1'b1;
      end else if (bus.i_pcc_fetch_req) begin
        mode_d    = MODE_INC;
        fetch_ack = 1'b1;
      end
    end
  end

`ifdef IDLI_PCC_IRQ_EN
  // EPC collects PC+1 from the PC block, LS slice first, across the interrupt window.
  always_comb begin
    irq_win_d = irq_win_q;
    epc_d     = epc_q;
    if (irq_win_q) begin
      epc_d = {bus.i_pcc_pc_next, epc_q[15:4]};
    end
    if (decide) begin
      irq_win_d = irq_req;
    end
  end

  assign bus.o_pcc_irq_ack = decide & irq_req;
  assign bus.o_pcc_epc     = epc_q;
`endif

  assign bus.o_pcc_fetch_ack = fetch_ack;
  assign bus.o_pcc_br_rdy    = br_rdy;
  assign bus.o_pcc_ctr       = ctr_q;
  assign bus.o_pcc_inc       = (mode_q == MODE_INC);
  assign bus.o_pcc_redirect  = (mode_q == MODE_REDIR);
  assign bus.o_pcc_data      = tgt_q[{ctr_q, 2'b00} +: 4];
endmodule

// File: tb/tb_idli_pc_ctl_m.sv
// tb/tb_idli_pc_ctl_m.sv - self-checking bench for idli_pc_ctl_m against a window-level model
// Interrupt scenarios run when IDLI_PCC_IRQ_EN is defined.
module tb_idli_pc_ctl_m;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  idli_pc_ctl_m_if bus();

  idli_pc_ctl_m dut (
    .i_pcc_gck   (clk),
    .i_pcc_rst_n (rst_n),
    .bus         (bus)
  );

  int total = 0;
  int bad   = 0;

  logic        fetch_req = 1'b0;
  logic        br_vld    = 1'b0;
  logic [15:0] br_tgt    = 16'h0;
  logic        irq       = 1'b0;
  logic        irq_ack_w;
  logic [15:0] epc_w;

  assign bus.i_pcc_fetch_req = fetch_req;
  assign bus.i_pcc_br_vld    = br_vld;
  assign bus.i_pcc_br_tgt    = br_tgt;
`ifdef IDLI_PCC_IRQ_EN
  assign bus.i_pcc_irq = irq;
  assign irq_ack_w     = bus.o_pcc_irq_ack;
  assign epc_w         = bus.o_pcc_epc;
`else
  assign irq_ack_w = 1'b0;
  assign epc_w     = 16'h0;
`endif

  // Bit-serial PC block driven only by the DUT's ctr/inc/redirect/data outputs.
  logic [15:0] pc_emul, win_pc, base_w, nxt_w;
  logic        carry;
  logic [4:0]  sum_w;
  assign sum_w  = {1'b0, pc_emul[{bus.o_pcc_ctr, 2'b00} +: 4]} +
                  ((bus.o_pcc_ctr == 2'd0) ? 5'd1 : {4'd0, carry});
  assign base_w = (bus.o_pcc_ctr == 2'd0) ? pc_emul : win_pc;
  assign nxt_w  = base_w + 16'd1;
  assign bus.i_pcc_pc_next = nxt_w[{bus.o_pcc_ctr, 2'b00} +: 4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_emul <= 16'h0;
      win_pc  <= 16'h0;
      carry   <= 1'b0;
    end else begin
      if (bus.o_pcc_ctr == 2'd0) win_pc <= pc_emul;
      if (bus.o_pcc_inc) begin
        pc_emul[{bus.o_pcc_ctr, 2'b00} +: 4] <= sum_w[3:0];
        carry <= sum_w[4];
      end else if (bus.o_pcc_redirect) begin
        pc_emul[{bus.o_pcc_ctr, 2'b00} +: 4] <= bus.o_pcc_data;
      end
    end
  end

  // Reference model: one action per window, PC updated as a whole word at window end.
  logic [1:0]  m_ctr;
  int          m_mode;
  logic [15:0] m_tgt, m_pc, m_epc;
  bit          m_irq_win;
  bit          e_fa, e_br, e_irq;
  logic [10:0] exp_vec, obs;

  assign obs = {bus.o_pcc_ctr, bus.o_pcc_inc, bus.o_pcc_redirect, bus.o_pcc_data,
                bus.o_pcc_fetch_ack, bus.o_pcc_br_rdy, irq_ack_w};

  task automatic model_reset();
    m_ctr = 2'd0; m_mode = 0; m_tgt = 16'h0; m_pc = 16'h0; m_epc = 16'h0;
    m_irq_win = 1'b0; e_fa = 1'b0; e_br = 1'b0; e_irq = 1'b0;
  endtask

  task automatic model_eval();
    e_fa = 1'b0; e_br = 1'b0; e_irq = 1'b0;
    if (m_ctr == 2'd3) begin
      if (irq) e_irq = 1'b1;
      else if (br_vld) e_br = 1'b1;
      else if (fetch_req) e_fa = 1'b1;
    end
    exp_vec = {m_ctr, m_mode == 1, m_mode == 2, 4'((m_tgt >> (4 * m_ctr)) & 16'hF),
               e_fa, e_br, e_irq};
  endtask

  task automatic model_adv();
    if (m_ctr == 2'd3) begin
      if (m_mode == 1) m_pc = m_pc + 16'd1;
      else if (m_mode == 2) begin
        if (m_irq_win) m_epc = m_pc + 16'd1;
        m_pc = m_tgt;
      end
      m_mode = 0; m_irq_win = 1'b0;
      if (e_irq) begin m_mode = 2; m_tgt = 16'hFFF0; m_irq_win = 1'b1; end
      else if (e_br) begin m_mode = 2; m_tgt = br_tgt; end
      else if (e_fa) m_mode = 1;
    end
    m_ctr = m_ctr + 2'd1;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_adv();
    @(negedge clk);
  endtask

  task automatic step_to(input logic [1:0] c);
    fetch_req = 1'b0; br_vld = 1'b0; irq = 1'b0;
    while (m_ctr != c) begin settle(); advance(); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; fetch_req = 1'b0; br_vld = 1'b0; irq = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs !== 11'h0 || epc_w !== 16'h0) begin
      bad++; $display("FAIL reset_outputs got=%h/%h want=0/0", obs, epc_w);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      settle();
      total++;
      if (obs !== exp_vec) begin bad++; $display("FAIL reset_idle_vec c=%0d got=%h want=%h", c, obs, exp_vec); end
      total++;
      if (bus.o_pcc_ctr !== 2'(c % 4) || bus.o_pcc_inc !== 1'b0 || bus.o_pcc_redirect !== 1'b0) begin
        bad++; $display("FAIL reset_idle_ctr c=%0d got=%0d/%b/%b want=%0d/0/0", c, bus.o_pcc_ctr,
                        bus.o_pcc_inc, bus.o_pcc_redirect, c % 4);
      end
      total++;
      if (pc_emul !== 16'h0) begin bad++; $display("FAIL reset_idle_pc got=%h want=0000", pc_emul); end
      advance();
    end
  endtask

  task automatic test_fetch();
    @(negedge clk); rst_n = 1'b0; model_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      fetch_req = (c < 16);
      settle();
      total++;
      if (obs !== exp_vec) begin bad++; $display("FAIL fetch_vec c=%0d got=%h want=%h", c, obs, exp_vec); end
      total++;
      if (bus.o_pcc_fetch_ack !== ((c % 4 == 3) && c < 16)) begin
        bad++; $display("FAIL fetch_ack c=%0d got=%b want=%b", c, bus.o_pcc_fetch_ack, (c % 4 == 3));
      end
      if (c >= 8 && c % 4 == 0) begin
        total++;
        if (pc_emul !== 16'(c / 4 - 1)) begin
          bad++; $display("FAIL fetch_pc c=%0d got=%h want=%h", c, pc_emul, 16'(c / 4 - 1));
        end
      end
      advance();
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_branch();
    step_to(2'd1);
    br_vld = 1'b1; br_tgt = 16'h1234;
    for (int c = 0; c < 8; c++) begin
      settle();
      total++;
      if (obs !== exp_vec) begin bad++; $display("FAIL branch_vec c=%0d got=%h want=%h", c, obs, exp_vec); end
      if (c == 2) begin
        total++;
        if (bus.o_pcc_br_rdy !== 1'b1) begin bad++; $display("FAIL branch_rdy got=%b want=1", bus.o_pcc_br_rdy); end
      end
      if (c >= 3 && c <= 6) begin
        total++;
        if (bus.o_pcc_data !== 4'(7 - c) || bus.o_pcc_redirect !== 1'b1) begin
          bad++; $display("FAIL branch_data c=%0d got=%h/%b want=%h/1", c, bus.o_pcc_data, bus.o_pcc_redirect, 4'(7 - c));
        end
      end
      if (c == 7) begin
        total++;
        if (pc_emul !== 16'h1234) begin bad++; $display("FAIL branch_pc got=%h want=1234", pc_emul); end
      end
      advance();
      if (c == 2) br_vld = 1'b0;
    end
  endtask

  task automatic test_priority();
    step_to(2'd3);
    br_tgt = 16'h00A0;
    for (int k = 0; k <= 9; k++) begin
      br_vld = (k == 0); fetch_req = (k <= 4);
      settle();
      total++;
      if (obs !== exp_vec) begin bad++; $display("FAIL prio_vec k=%0d got=%h want=%h", k, obs, exp_vec); end
      if (k == 0) begin
        total++;
        if (bus.o_pcc_br_rdy !== 1'b1 || bus.o_pcc_fetch_ack !== 1'b0) begin
          bad++; $display("FAIL prio_acks got=%b/%b want=1/0", bus.o_pcc_br_rdy, bus.o_pcc_fetch_ack);
        end
      end
      if (k == 4) begin
        total++;
        if (bus.o_pcc_fetch_ack !== 1'b1) begin bad++; $display("FAIL prio_late_fetch got=%b want=1", bus.o_pcc_fetch_ack); end
      end
      if (k == 9) begin
        total++;
        if (pc_emul !== 16'h00A1) begin bad++; $display("FAIL prio_pc got=%h want=00a1", pc_emul); end
      end
      advance();
    end
    fetch_req = 1'b0;
  endtask

`ifdef IDLI_PCC_IRQ_EN
  task automatic test_irq();
    step_to(2'd3);
    for (int k = 0; k <= 13; k++) begin
      br_vld    = (k == 0) || (k == 8);
      br_tgt    = (k == 0) ? 16'h0040 : 16'h5555;
      fetch_req = (k == 4) || (k == 8);
      irq       = (k == 8);
      settle();
      total++;
      if (obs !== exp_vec) begin bad++; $display("FAIL irq_vec k=%0d got=%h want=%h", k, obs, exp_vec); end
      if (k == 8) begin
        total++;
        if (irq_ack_w !== 1'b1 || bus.o_pcc_br_rdy !== 1'b0 || bus.o_pcc_fetch_ack !== 1'b0) begin
          bad++; $display("FAIL irq_acks got=%b/%b/%b want=1/0/0", irq_ack_w, bus.o_pcc_br_rdy, bus.o_pcc_fetch_ack);
        end
      end
      if (k == 9) begin
        total++;
        if (pc_emul !== 16'h0041) begin bad++; $display("FAIL irq_pre_pc got=%h want=0041", pc_emul); end
      end
      if (k == 13) begin
        total++;
        if (pc_emul !== 16'hFFF0 || epc_w !== 16'h0042) begin
          bad++; $display("FAIL irq_pc_epc got=%h/%h want=fff0/0042", pc_emul, epc_w);
        end
      end
      advance();
    end
    br_vld = 1'b0; fetch_req = 1'b0; irq = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    step_to(2'd3);
    br_tgt = 16'hBEEF;
    for (int k = 0; k < 3; k++) begin
      br_vld = (k == 0);
      settle();
      total++;
      if (obs !== exp_vec) begin bad++; $display("FAIL mid_vec k=%0d got=%h want=%h", k, obs, exp_vec); end
      advance();
    end
    settle();
    total++;
    if (bus.o_pcc_redirect !== 1'b1 || bus.o_pcc_ctr !== 2'd2) begin
      bad++; $display("FAIL mid_pre got=%b/%0d want=1/2", bus.o_pcc_redirect, bus.o_pcc_ctr);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs !== 11'h0) begin bad++; $display("FAIL mid_reset_outputs got=%h want=000", obs); end
`ifdef IDLI_PCC_IRQ_EN
    total++;
    if (epc_w !== 16'h0) begin bad++; $display("FAIL mid_reset_epc got=%h want=0000", epc_w); end
`endif
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    fetch_req = 1'b1;
    for (int j = 0; j <= 4; j++) begin
      settle();
      total++;
      if (obs !== exp_vec) begin bad++; $display("FAIL mid_post_vec j=%0d got=%h want=%h", j, obs, exp_vec); end
      total++;
      if (bus.o_pcc_inc !== (j == 4) || bus.o_pcc_redirect !== 1'b0 || bus.o_pcc_data !== 4'h0) begin
        bad++; $display("FAIL mid_post_mode j=%0d got=%b/%b/%h want=%b/0/0", j, bus.o_pcc_inc,
                        bus.o_pcc_redirect, bus.o_pcc_data, (j == 4));
      end
      advance();
      if (j == 3) fetch_req = 1'b0;
    end
  endtask

  task automatic test_random();
    e_fa = 1'b0; e_br = 1'b0; e_irq = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!fetch_req || e_fa) fetch_req = ($urandom_range(0, 2) == 0);
      if (!br_vld || e_br) begin
        br_vld = ($urandom_range(0, 3) == 0);
        br_tgt = 16'($urandom);
      end
`ifdef IDLI_PCC_IRQ_EN
      if (!irq || e_irq) irq = ($urandom_range(0, 7) == 0);
`endif
      settle();
      total++;
      if (obs !== exp_vec) begin bad++; $display("FAIL rand_vec c=%0d got=%h want=%h", c, obs, exp_vec); end
      if (m_ctr == 2'd0) begin
        total++;
        if (pc_emul !== m_pc) begin bad++; $display("FAIL rand_pc c=%0d got=%h want=%h", c, pc_emul, m_pc); end
`ifdef IDLI_PCC_IRQ_EN
        total++;
        if (epc_w !== m_epc) begin bad++; $display("FAIL rand_epc c=%0d got=%h want=%h", c, epc_w, m_epc); end
`endif
      end
      advance();
    end
    fetch_req = 1'b0; br_vld = 1'b0; irq = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fetch();
    test_branch();
    test_priority();
`ifdef IDLI_PCC_IRQ_EN
    test_irq();
`endif
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/idli_pc_ctl_m.md
# idli_pc_ctl_m

Sequencer for the bit-serial PC slice datapath. Owns the 2-bit slice counter, and once per 4-cycle word window picks exactly one action for the next window: hold, increment, or redirect. Arbitrates between the fetch sequencer (sequential increment), the branch unit (redirect to a target) and, optionally, an interrupt source (redirect to a vector). Its outputs drive the PC block's counter, increment, redirect and data inputs directly.

## Interface

- IRQ_VECTOR, 16'hFFF0, redirect target used for interrupts (data_t).
- i_pcc_gck  in  1  clock.
- i_pcc_rst_n  in  1  asynchronous active-low reset.
- i_pcc_fetch_req  in  1  fetch sequencer requests the next sequential word; level, held until ack.
- o_pcc_fetch_ack  out  1  one-cycle pulse: increment granted for the next window.
- i_pcc_br_vld  in  1  branch redirect request; held with a stable target until ready.
- i_pcc_br_tgt  in  16  branch target address (data_t).
- o_pcc_br_rdy  out  1  one-cycle pulse: branch accepted and target captured.
- i_pcc_pc_next  in  4  next sequential PC slice from the PC block (slice_t).
- o_pcc_ctr  out  2  slice index to the PC block (ctr_t).
- o_pcc_inc  out  1  increment control to the PC block.
- o_pcc_redirect  out  1  redirect control to the PC block.
- o_pcc_data  out  4  redirect data slice to the PC block (slice_t).
- i_pcc_irq, o_pcc_irq_ack, o_pcc_epc (1/1/16): present only with IDLI_PCC_IRQ_EN.

## Operation

- **Slice counter (ctr):** free-running, 0→1→2→3→0. Slice 0 is the least-significant nibble. A window is the four cycles with ctr = 0..3.
- **Decision point:** the clock edge at which ctr = 3. The decision is registered and held in one of three modes for the whole next window: HOLD, INC or REDIR. It is not modified mid-window.
- **Priority at the decision point:** irq (if compiled in) > branch > fetch > HOLD.
  - REDIR (branch):
    - o_pcc_br_rdy = 1 in the ctr = 3 cycle.
    - tgt_q ← i_pcc_br_tgt at that edge.
  - INC: o_pcc_fetch_ack = 1 in the ctr = 3 cycle.
  - HOLD: no request pending.
- **Loser behaviour:** requests that lose arbitration get no ack. They must stay asserted and are re-evaluated at the next decision point.
- **Mode encoding:**
  - o_pcc_inc = (mode == INC).
  - o_pcc_redirect = (mode == REDIR).
  - Both are registered.
- **Data path:** o_pcc_data = tgt_q[4*ctr +: 4]. This is combinational from registers and valid in every cycle.
- **Acks:** fetch_ack and br_rdy are combinational with the ctr = 3 cycle (Mealy on registered ctr plus inputs).
  - Requesters must drop or re-arm a request after its ack.
  - A request still high after its ack is treated as a new request at the next decision point.
- **Reset:**
  - ctr = 0, mode = HOLD, tgt_q = 0.
  - All outputs are 0: ctr, inc, redirect, data, fetch_ack, br_rdy, irq_ack, epc.
  - Reset asserted mid-window aborts the window immediately. No partial redirect state survives.

## Timing

- A request sampled at decision point N takes effect on the PC over the four cycles following that edge. The PC holds the new value after window end, i.e. 5 cycles after the ack cycle.
- After reset the first window is always HOLD: no decision point has occurred yet.
- Back-to-back INC: with fetch_req held high, fetch_ack pulses every 4 cycles and the PC advances by 1 per window.
- If br_vld rises at ctr = 0..2, it waits for ctr = 3. Worst-case accept latency is 4 cycles.
- Changing i_pcc_br_tgt while br_vld = 1 and before br_rdy is illegal. The target is sampled only at the accept edge.
- Wrap-around: INC from 16'hFFFF gives 0. This is handled by the PC carry chain, not by this block.

## Configuration

- IDLI_PCC_IRQ_EN defined:
  - Adds i_pcc_irq (level), o_pcc_irq_ack (one-cycle pulse at ctr = 3 when granted) and o_pcc_epc (data_t).
  - An irq grant forces REDIR with tgt_q ← IRQ_VECTOR.
  - During that REDIR window, epc shifts in i_pcc_pc_next one slice per cycle. At window end epc = old PC + 1.
  - Branch and fetch requests in the same decision cycle are not acked.
- IDLI_PCC_IRQ_EN undefined:
  - The irq/epc ports are absent.
  - The priority chain is branch > fetch > HOLD.

## Test plan

- Reset, no requests for 12 cycles:
  - ctr cycles 0,1,2,3.
  - inc = redirect = 0 throughout.
  - PC model stays at 0.
- fetch_req held high from reset for 16 cycles:
  - fetch_ack at cycles 3, 7, 11, 15.
  - PC model reads 1, 2, 3 after each INC window.
- br_vld with tgt 16'h1234 raised at ctr = 1:
  - br_rdy at the next ctr = 3.
  - o_pcc_data = 4, 3, 2, 1 over the REDIR window.
  - PC = 16'h1234 afterwards.
- br_vld (tgt 16'h00A0) and fetch_req both high at ctr = 3:
  - Only br_rdy pulses and the window is REDIR.
  - fetch_ack follows at the next decision point.
  - PC ends at 16'h00A1.
- IRQ_EN with PC = 16'h0041 and irq, br_vld, fetch_req all high:
  - Only irq_ack pulses.
  - PC = 16'hFFF0 and epc = 16'h0042.
- rst_n asserted at ctr = 2 of a REDIR window, then released:
  - All outputs are 0 immediately.
  - The first post-reset window is HOLD.
